mux4_rr_arbiter: RTL

//   Round-robin arbiter and sequencer for the shared 4-to-1 mux datapath.

---
 rtl/mux4_rr_arbiter_pkg.sv | 17 +
 rtl/mux4_rr_arbiter_if.sv | 25 ++
 rtl/mux4_rr_arbiter_pick.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and helpers for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bus of the arbitrated 4-to-1 mux: requests and lanes in, grant and registered output back.
interface mux4_rr_arbiter_if
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DW = 1
) ();

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] in;
  logic [NUM_REQ-1:0]    gnt;
  logic [SEL_W-1:0]      sel;
  logic                  valid;
  logic [DW-1:0]         out;

  modport master (
    output req, in,
    input  gnt, sel, valid, out
  );

  modport slave (
    input  req, in,
    output gnt, sel, valid, out
  );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first set request after position last_i, wrapping mod 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic               found_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = last_i;
    cand    = last_i;
    // last_i itself is searched last (k == NUM_REQ wraps back onto it)
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_i + SEL_W'(k);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4-to-1 mux with registered output and valid flag.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  mux4_rr_arbiter_if.slave bus
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be >= 2");
  end

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      out_q, out_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   pick_last;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned    CNT_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             others_req;

  assign others_req = |(bus.req & ~gnt_q);
`endif

  // While granted, the search starts after the current owner so a release or
  // preemption rotates past it without waiting for last_q to update.
  assign pick_last = (state_q == ST_GRANT) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req_i   (bus.req),
    .last_i  (pick_last),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = |gnt_q;
    out_d   = out_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    if (|gnt_q) begin
      out_d = bus.in[sel_q*DW +: DW];
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!bus.req[sel_q]) begin
          last_d = sel_q;
          if (pick_found) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          // Saturated: hand over only if someone else is waiting.
          if (others_req) begin
            last_d     = sel_q;
            gnt_d      = onehot(pick_idx);
            sel_d      = pick_idx;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= SEL_W'(NUM_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.out   = out_q;

endmodule
